// File: rtl/i2s_rx_slave.sv
`default_nettype none
// ============================================================================
//  Module      : i2s_rx_slave
//  Description : I2S slave receiver. Oversamples BCK/LRCK/SDIN on mclk_in,
//                deserialises MSB-first words and presents one left/right
//                pair per frame with a single-cycle valid strobe, the bit
//                count of the right word and a left/right length mismatch flag.
//  Revision    : 1.0  initial release
// ============================================================================
module i2s_rx_slave #(
    parameter int DATA_WIDTH = 24   // must not exceed 63 (6-bit bit counter)
) (
    input  logic                  mclk_in,
    input  logic                  rst,
    input  logic                  enable,
    input  logic                  bck,
    input  logic                  lrck,
    input  logic                  sdin,
    output logic [DATA_WIDTH-1:0] left_data,
    output logic [DATA_WIDTH-1:0] right_data,
    output logic                  sample_valid,
    output logic [5:0]            bits_per_ch,
    output logic                  len_err
);

    localparam logic [1:0] c_st_sync  = 2'd0;
    localparam logic [1:0] c_st_left  = 2'd1;
    localparam logic [1:0] c_st_right = 2'd2;
    localparam logic [5:0] c_cnt_max  = 6'd63;

    // synchroniser stages; stage 3 of bck only serves edge detection
    logic r_bck_s1, r_bck_s2, r_bck_s3;
    logic r_lrck_s1, r_lrck_s2;
    logic r_sdin_s1, r_sdin_s2;

    logic w_bck_rise;
    logic w_lrck_s;
    logic w_sdin_s;

    // receiver state
    logic [1:0]            r_state;
    logic [1:0]            w_state_nxt;
    logic [5:0]            r_cnt;
    logic [5:0]            w_cnt_nxt;
    logic [5:0]            w_cnt_inc;
    logic [DATA_WIDTH-1:0] r_sr;
    logic [DATA_WIDTH-1:0] w_sr_nxt;
    logic [DATA_WIDTH-1:0] w_sr_ins;
    logic [DATA_WIDTH-1:0] r_left_word;
    logic [DATA_WIDTH-1:0] w_left_word_nxt;
    logic [5:0]            r_left_cnt;
    logic [5:0]            w_left_cnt_nxt;
    logic                  r_lrck_prev;
    logic                  w_word_end;
    logic                  w_pair_done;

    // output registers
    logic [DATA_WIDTH-1:0] r_left_data;
    logic [DATA_WIDTH-1:0] r_right_data;
    logic                  r_sample_valid;
    logic [5:0]            r_bits_per_ch;
    logic                  r_len_err;

    // Two-flop synchronisers; lrck/sdin share the same depth so they stay
    // aligned with the bck edge that qualifies them.
    always_ff @(posedge mclk_in) begin
        if (rst) begin
            r_bck_s1  <= 1'b0;
            r_bck_s2  <= 1'b0;
            r_bck_s3  <= 1'b0;
            r_lrck_s1 <= 1'b0;
            r_lrck_s2 <= 1'b0;
            r_sdin_s1 <= 1'b0;
            r_sdin_s2 <= 1'b0;
        end else begin
            r_bck_s1  <= bck;
            r_bck_s2  <= r_bck_s1;
            r_bck_s3  <= r_bck_s2;
            r_lrck_s1 <= lrck;
            r_lrck_s2 <= r_lrck_s1;
            r_sdin_s1 <= sdin;
            r_sdin_s2 <= r_sdin_s1;
        end
    end

    assign w_bck_rise = r_bck_s2 & ~r_bck_s3;
    assign w_lrck_s   = r_lrck_s2;
    assign w_sdin_s   = r_sdin_s2;
    assign w_word_end = (w_lrck_s != r_lrck_prev);
    assign w_cnt_inc  = (r_cnt == c_cnt_max) ? r_cnt : r_cnt + 6'd1;

    // Shift register with the current bit dropped into its MSB-first slot;
    // bits beyond DATA_WIDTH match no slot and are discarded.
    always_comb begin
        w_sr_ins = r_sr;
        for (int i = 0; i < DATA_WIDTH; i++) begin
            if (r_cnt == 6'(DATA_WIDTH - 1 - i)) begin
                w_sr_ins[i] = w_sdin_s;
            end
        end
    end

    // LRCK of the previous bck rise tells which channel the current bit is for.
    always_ff @(posedge mclk_in) begin
        if (rst) begin
            r_lrck_prev <= 1'b1;
        end else if (w_bck_rise) begin
            r_lrck_prev <= w_lrck_s;
        end
    end

    // Next-state / datapath decode for the SYNC -> LEFT -> RIGHT word machine.
    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt;
        w_sr_nxt        = r_sr;
        w_left_word_nxt = r_left_word;
        w_left_cnt_nxt  = r_left_cnt;
        w_pair_done     = 1'b0;

        if (!enable) begin
            w_state_nxt = c_st_sync;
            w_cnt_nxt   = 6'd0;
            w_sr_nxt    = '0;
        end else if (w_bck_rise) begin
            case (r_state)
                c_st_sync: begin
                    if (r_lrck_prev && !w_lrck_s) begin
                        w_state_nxt = c_st_left;
                        w_cnt_nxt   = 6'd0;
                        w_sr_nxt    = '0;
                    end
                end
                c_st_left: begin
                    if (!w_word_end) begin
                        w_sr_nxt  = w_sr_ins;
                        w_cnt_nxt = w_cnt_inc;
                    end else if (!r_lrck_prev && w_lrck_s) begin
                        w_left_word_nxt = w_sr_ins;
                        w_left_cnt_nxt  = w_cnt_inc;
                        w_cnt_nxt       = 6'd0;
                        w_sr_nxt        = '0;
                        w_state_nxt     = c_st_right;
                    end else begin
                        w_state_nxt = c_st_sync;
                        w_cnt_nxt   = 6'd0;
                        w_sr_nxt    = '0;
                    end
                end
                c_st_right: begin
                    if (!w_word_end) begin
                        w_sr_nxt  = w_sr_ins;
                        w_cnt_nxt = w_cnt_inc;
                    end else if (r_lrck_prev && !w_lrck_s) begin
                        w_pair_done = 1'b1;
                        w_cnt_nxt   = 6'd0;
                        w_sr_nxt    = '0;
                        w_state_nxt = c_st_left;
                    end else begin
                        w_state_nxt = c_st_sync;
                        w_cnt_nxt   = 6'd0;
                        w_sr_nxt    = '0;
                    end
                end
                default: begin
                    w_state_nxt = c_st_sync;
                    w_cnt_nxt   = 6'd0;
                    w_sr_nxt    = '0;
                end
            endcase
        end
    end

    // State, bit counter, shift register and held left word.
    always_ff @(posedge mclk_in) begin
        if (rst) begin
            r_state     <= c_st_sync;
            r_cnt       <= 6'd0;
            r_sr        <= '0;
            r_left_word <= '0;
            r_left_cnt  <= 6'd0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_sr        <= w_sr_nxt;
            r_left_word <= w_left_word_nxt;
            r_left_cnt  <= w_left_cnt_nxt;
        end
    end

    // Publish a completed pair; the strobe lands with the new data one cycle
    // after the right word's LSB rise.
    always_ff @(posedge mclk_in) begin
        if (rst) begin
            r_left_data    <= '0;
            r_right_data   <= '0;
            r_sample_valid <= 1'b0;
            r_bits_per_ch  <= 6'd0;
            r_len_err      <= 1'b0;
        end else begin
            r_sample_valid <= w_pair_done;
            if (w_pair_done) begin
                r_left_data   <= r_left_word;
                r_right_data  <= w_sr_ins;
                r_bits_per_ch <= w_cnt_inc;
                r_len_err     <= (w_cnt_inc != r_left_cnt);
            end
        end
    end

    assign left_data    = r_left_data;
    assign right_data   = r_right_data;
    assign sample_valid = r_sample_valid;
    assign bits_per_ch  = r_bits_per_ch;
    assign len_err      = r_len_err;

endmodule
`default_nettype wire

// File: tb/tb_i2s_rx_slave.sv
`default_nettype none
// ============================================================================
//  Module      : tb_i2s_rx_slave
//  Description : Self-checking bench for i2s_rx_slave. Streams word lists as
//                I2S frames (BCK = mclk/8) and compares each captured pair
//                with values computed from the transmitted words.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_i2s_rx_slave;

    localparam int DW = 24;

    logic          mclk_in = 1'b0;
    logic          rst;
    logic          enable;
    logic          bck;
    logic          lrck;
    logic          sdin;
    logic [DW-1:0] left_data;
    logic [DW-1:0] right_data;
    logic          sample_valid;
    logic [5:0]    bits_per_ch;
    logic          len_err;

    always #5 mclk_in = ~mclk_in;

    i2s_rx_slave #(.DATA_WIDTH(DW)) dut (
        .mclk_in      (mclk_in),
        .rst          (rst),
        .enable       (enable),
        .bck          (bck),
        .lrck         (lrck),
        .sdin         (sdin),
        .left_data    (left_data),
        .right_data   (right_data),
        .sample_valid (sample_valid),
        .bits_per_ch  (bits_per_ch),
        .len_err      (len_err)
    );

    typedef struct {
        logic [DW-1:0] l;
        logic [DW-1:0] r;
        logic [5:0]    bits;
        logic          err;
    } pair_t;

    pair_t        exp_q[$];
    pair_t        got_q[$];
    bit           seg_ch[$];
    int           seg_len[$];
    logic [127:0] seg_val[$];

    int   checks   = 0;
    int   failures = 0;
    int   b2b      = 0;
    logic sv_d     = 1'b0;

    logic [DW-1:0] held_l;
    logic [DW-1:0] held_r;
    logic [5:0]    held_bits;
    logic          held_err;

    // capture every strobe and note any strobe on consecutive cycles
    always @(negedge mclk_in) begin
        if (sample_valid) begin
            got_q.push_back('{l: left_data, r: right_data, bits: bits_per_ch, err: len_err});
        end
        if (sample_valid && sv_d) begin
            b2b <= b2b + 1;
        end
        sv_d <= sample_valid;
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic logic [DW-1:0] justify(input logic [127:0] v, input int len);
        if (len >= DW) return DW'(v >> (len - DW));
        else           return DW'(v << (DW - len));
    endfunction

    function automatic logic [5:0] sat63(input int n);
        return (n > 63) ? 6'd63 : 6'(n);
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic add_word(input bit ch, input int len, input logic [127:0] v);
        seg_ch.push_back(ch);
        seg_len.push_back(len);
        seg_val.push_back(v & ((128'd1 << len) - 128'd1));
    endtask

    task automatic add_frame(input int llen, input logic [127:0] lv,
                             input int rlen, input logic [127:0] rv, input bit expect_it);
        logic [127:0] lm;
        logic [127:0] rm;
        lm = lv & ((128'd1 << llen) - 128'd1);
        rm = rv & ((128'd1 << rlen) - 128'd1);
        add_word(1'b0, llen, lm);
        add_word(1'b1, rlen, rm);
        if (expect_it) begin
            exp_q.push_back('{l: justify(lm, llen), r: justify(rm, rlen),
                              bits: sat63(rlen), err: (sat63(llen) != sat63(rlen))});
        end
    endtask

    // Flatten the word list into bits; LRCK in each BCK period announces the
    // channel of the following bit (one-BCK I2S delay).
    task automatic send_stream();
        bit bits[$];
        bit chs[$];
        for (int w = 0; w < seg_len.size(); w++) begin
            for (int k = 0; k < seg_len[w]; k++) begin
                bits.push_back(seg_val[w][seg_len[w] - 1 - k]);
                chs.push_back(seg_ch[w]);
            end
        end
        for (int j = 0; j < bits.size(); j++) begin
            bck  = 1'b0;
            sdin = bits[j];
            lrck = (j + 1 < bits.size()) ? chs[j + 1] : chs[j];
            repeat (4) @(negedge mclk_in);
            bck = 1'b1;
            repeat (4) @(negedge mclk_in);
        end
        bck = 1'b0;
        repeat (20) @(negedge mclk_in);
        seg_ch.delete();
        seg_len.delete();
        seg_val.delete();
    endtask

    task automatic check_pairs(input string tag);
        int n;
        repeat (10) @(negedge mclk_in);
        chk({tag, "_count"}, 128'(got_q.size()), 128'(exp_q.size()));
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            chk($sformatf("%s_left%0d", tag, i),  128'(got_q[i].l),    128'(exp_q[i].l));
            chk($sformatf("%s_right%0d", tag, i), 128'(got_q[i].r),    128'(exp_q[i].r));
            chk($sformatf("%s_bits%0d", tag, i),  128'(got_q[i].bits), 128'(exp_q[i].bits));
            chk($sformatf("%s_err%0d", tag, i),   128'(got_q[i].err),  128'(exp_q[i].err));
        end
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic resync();
        enable = 1'b0;
        @(negedge mclk_in);
        enable = 1'b1;
        @(negedge mclk_in);
    endtask

    initial begin
        rst    = 1'b1;
        enable = 1'b1;
        bck    = 1'b0;
        lrck   = 1'b1;
        sdin   = 1'b0;
        repeat (5) @(negedge mclk_in);
        rst = 1'b0;
        @(negedge mclk_in);
        chk("rst_left",  128'(left_data),    128'd0);
        chk("rst_right", 128'(right_data),   128'd0);
        chk("rst_valid", 128'(sample_valid), 128'd0);
        chk("rst_bits",  128'(bits_per_ch),  128'd0);
        chk("rst_err",   128'(len_err),      128'd0);

        // 32-bit frames, starting mid right word; partial word must never show
        add_word(1'b1, 5, rnd128());
        add_frame(32, rnd128(), 32, rnd128(), 1'b1);
        add_frame(32, rnd128(), 32, rnd128(), 1'b1);
        add_frame(32, 128'h123456AB, 32, 128'hFEDCBA98, 1'b1);
        add_word(1'b0, 3, rnd128());
        send_stream();
        check_pairs("f32");
        chk("f32_last_left",  128'(left_data),   128'h123456);
        chk("f32_last_right", 128'(right_data),  128'hFEDCBA);
        chk("f32_last_bits",  128'(bits_per_ch), 128'd32);

        // 16-bit frames: short words are zero padded at the bottom
        resync();
        add_word(1'b1, 4, rnd128());
        add_frame(16, rnd128(), 16, rnd128(), 1'b1);
        add_frame(16, 128'h8001, 16, 128'h7FFF, 1'b1);
        add_word(1'b0, 3, rnd128());
        send_stream();
        check_pairs("f16");
        chk("f16_last_left",  128'(left_data),  128'h800100);
        chk("f16_last_right", 128'(right_data), 128'h7FFF00);

        // unequal lengths, short/long words and bit-count saturation
        resync();
        add_word(1'b1, 6, rnd128());
        add_frame(32, rnd128(), 28, rnd128(), 1'b1);
        add_frame(40, rnd128(), 8,  rnd128(), 1'b1);
        add_frame(70, rnd128(), 70, rnd128(), 1'b1);
        add_word(1'b0, 3, rnd128());
        send_stream();
        check_pairs("mix");
        chk("sat_bits", 128'(bits_per_ch), 128'd63);
        chk("sat_err",  128'(len_err),     128'd0);

        // reset in the middle of a left word
        resync();
        add_word(1'b1, 3, rnd128());
        add_frame(32, rnd128(), 32, rnd128(), 1'b1);
        add_word(1'b0, 10, rnd128());
        send_stream();
        check_pairs("pre_rst");
        rst = 1'b1;
        @(negedge mclk_in);
        chk("midrst_left",  128'(left_data),   128'd0);
        chk("midrst_right", 128'(right_data),  128'd0);
        chk("midrst_bits",  128'(bits_per_ch), 128'd0);
        rst = 1'b0;
        @(negedge mclk_in);
        add_word(1'b1, 3, rnd128());
        add_frame(24, rnd128(), 24, rnd128(), 1'b1);
        add_word(1'b0, 3, rnd128());
        send_stream();
        check_pairs("post_rst");

        // disabled for three frames: no strobes, outputs held
        held_l    = left_data;
        held_r    = right_data;
        held_bits = bits_per_ch;
        held_err  = len_err;
        enable    = 1'b0;
        @(negedge mclk_in);
        add_word(1'b1, 3, rnd128());
        add_frame(32, rnd128(), 32, rnd128(), 1'b0);
        add_frame(32, rnd128(), 32, rnd128(), 1'b0);
        add_frame(32, rnd128(), 32, rnd128(), 1'b0);
        add_word(1'b0, 3, rnd128());
        send_stream();
        check_pairs("dis");
        chk("dis_left",  128'(left_data),   128'(held_l));
        chk("dis_right", 128'(right_data),  128'(held_r));
        chk("dis_bits",  128'(bits_per_ch), 128'(held_bits));
        chk("dis_err",   128'(len_err),     128'(held_err));
        enable = 1'b1;
        @(negedge mclk_in);
        add_word(1'b1, 5, rnd128());
        add_frame(32, rnd128(), 32, rnd128(), 1'b1);
        add_frame(20, rnd128(), 20, rnd128(), 1'b1);
        add_word(1'b0, 3, rnd128());
        send_stream();
        check_pairs("resume");

        chk("no_back_to_back", 128'(b2b), 128'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
